// File: rtl/riscv_defines.sv
// Shared definitions for the EX-stage tag-check unit: cause codes, FSM states
// and the security exception code reported to the controller.
package riscv_defines;

  typedef enum logic [2:0] {
    TAG_CAUSE_NONE = 3'd0,
    TAG_CAUSE_S1   = 3'd1,
    TAG_CAUSE_S2   = 3'd2,
    TAG_CAUSE_D    = 3'd3,
    TAG_CAUSE_PC   = 3'd4
  } tag_cause_t;

  typedef enum logic [1:0] {
    TAG_CHK_IDLE  = 2'd0,
    TAG_CHK_REQ   = 2'd1,
    TAG_CHK_BLOCK = 2'd2
  } tag_chk_state_t;

  localparam logic [5:0] EXC_CAUSE_SECURITY = 6'h1F;

endpackage

// File: rtl/riscv_tag_cause_prio.sv
// Priority encoder from tag-check hits to a cause code: PC > S1 > S2 > D.
module riscv_tag_cause_prio
  import riscv_defines::*;
(
  input  logic       hit_pc,
  input  logic       hit_s1,
  input  logic       hit_s2,
  input  logic       hit_d,
  output tag_cause_t cause
);

  always_comb begin
    cause = TAG_CAUSE_NONE;
    if (hit_pc)      cause = TAG_CAUSE_PC;
    else if (hit_s1) cause = TAG_CAUSE_S1;
    else if (hit_s2) cause = TAG_CAUSE_S2;
    else if (hit_d)  cause = TAG_CAUSE_D;
  end

endmodule

// File: rtl/riscv_tag_check_ex.sv
// EX-stage DIFT policy check: ID/EX capture of check enables, violation detect,
// req/ack exception handshake and stall. Optional counter: TAG_CHECK_COUNTER_EN.
module riscv_tag_check_ex
  import riscv_defines::*;
#(
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid_i,
  input  logic                 ex_ready_i,
  input  logic                 check_s1_i,
  input  logic                 check_s2_i,
  input  logic                 check_d_i,
  input  logic                 check_pc_i,
  input  logic [PC_WIDTH-1:0]  pc_id_i,
  input  logic                 rs1_tag_i,
  input  logic                 rs2_tag_i,
  input  logic                 rd_tag_i,
  input  logic                 pc_tag_i,
  input  logic                 exc_ack_i,
  input  logic                 flush_i,
  input  logic                 clear_i,
  output logic                 exc_req_o,
  output logic [2:0]           exc_cause_o,
  output logic [PC_WIDTH-1:0]  exc_pc_o,
  output logic                 ex_stall_o,
  output logic [CNT_WIDTH-1:0] viol_cnt_o
);

  // Handshake: exc_req_o stays high with stable cause/pc until the cycle
  // exc_ack_i is sampled high; the request drops on the following cycle.

  logic                ex_valid_q;
  logic                ex_s1_q, ex_s2_q, ex_d_q, ex_pc_en_q;
  logic [PC_WIDTH-1:0] ex_pc_q;
  tag_chk_state_t      state_q;
  tag_cause_t          cause_q;
  tag_cause_t          cause_next;
  logic [PC_WIDTH-1:0] exc_pc_q;
  logic                hit_pc, hit_s1, hit_s2, hit_d;
  logic                viol;
  logic                go_req;

  assign hit_pc = ex_pc_en_q & pc_tag_i;
  assign hit_s1 = ex_s1_q & rs1_tag_i;
  assign hit_s2 = ex_s2_q & rs2_tag_i;
  assign hit_d  = ex_d_q & rd_tag_i;

  assign viol   = ex_valid_q && (state_q == TAG_CHK_IDLE) &&
                  (hit_pc | hit_s1 | hit_s2 | hit_d);
  assign go_req = viol && !flush_i;

  assign ex_stall_o  = viol | (state_q != TAG_CHK_IDLE);
  assign exc_req_o   = (state_q == TAG_CHK_REQ);
  assign exc_cause_o = cause_q;
  assign exc_pc_o    = exc_pc_q;

  riscv_tag_cause_prio u_prio (
    .hit_pc (hit_pc),
    .hit_s1 (hit_s1),
    .hit_s2 (hit_s2),
    .hit_d  (hit_d),
    .cause  (cause_next)
  );

  // ID/EX register; a stalled EX holds the faulting instruction in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_s1_q    <= 1'b0;
      ex_s2_q    <= 1'b0;
      ex_d_q     <= 1'b0;
      ex_pc_en_q <= 1'b0;
      ex_pc_q    <= '0;
    end else if (flush_i) begin
      ex_valid_q <= 1'b0;
    end else if (ex_ready_i && !ex_stall_o) begin
      ex_valid_q <= id_valid_i;
      ex_s1_q    <= check_s1_i;
      ex_s2_q    <= check_s2_i;
      ex_d_q     <= check_d_i;
      ex_pc_en_q <= check_pc_i;
      ex_pc_q    <= pc_id_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= TAG_CHK_IDLE;
      cause_q  <= TAG_CAUSE_NONE;
      exc_pc_q <= '0;
    end else begin
      case (state_q)
        TAG_CHK_IDLE: begin
          if (go_req) begin
            state_q  <= TAG_CHK_REQ;
            cause_q  <= cause_next;
            exc_pc_q <= ex_pc_q;
          end else if (clear_i) begin
            cause_q  <= TAG_CAUSE_NONE;
            exc_pc_q <= '0;
          end
        end
        TAG_CHK_REQ: begin
          // A flush alone does not retract an outstanding request.
          if (exc_ack_i && flush_i) state_q <= TAG_CHK_IDLE;
          else if (exc_ack_i)       state_q <= TAG_CHK_BLOCK;
        end
        TAG_CHK_BLOCK: begin
          if (flush_i) state_q <= TAG_CHK_IDLE;
          if (clear_i) begin
            cause_q  <= TAG_CAUSE_NONE;
            exc_pc_q <= '0;
          end
        end
        default: state_q <= TAG_CHK_IDLE;
      endcase
    end
  end

`ifdef TAG_CHECK_COUNTER_EN
  logic [CNT_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        cnt_q <= '0;
    else if (clear_i)               cnt_q <= '0;
    else if (go_req && cnt_q != '1) cnt_q <= cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  end

  assign viol_cnt_o = cnt_q;
`else
  assign viol_cnt_o = '0;
`endif

endmodule

// File: tb/tb_riscv_tag_check_ex.sv
// Self-checking bench for riscv_tag_check_ex: directed scenarios plus random
// traffic, compared each cycle against a behavioural reference model.
module tb_riscv_tag_check_ex;

  localparam int PC_W  = 32;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid_i, ex_ready_i;
  logic             check_s1_i, check_s2_i, check_d_i, check_pc_i;
  logic [PC_W-1:0]  pc_id_i;
  logic             rs1_tag_i, rs2_tag_i, rd_tag_i, pc_tag_i;
  logic             exc_ack_i, flush_i, clear_i;
  logic             exc_req_o;
  logic [2:0]       exc_cause_o;
  logic [PC_W-1:0]  exc_pc_o;
  logic             ex_stall_o;
  logic [CNT_W-1:0] viol_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  bit              m_valid;
  bit [3:0]        m_chk;     // {pc, s1, s2, d}
  bit [PC_W-1:0]   m_ex_pc;
  bit              m_pending, m_blocked;
  int              m_cause;
  bit [PC_W-1:0]   m_pc;
  int              m_cnt;

  riscv_tag_check_ex #(.PC_WIDTH(PC_W), .CNT_WIDTH(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid_i  (id_valid_i),
    .ex_ready_i  (ex_ready_i),
    .check_s1_i  (check_s1_i),
    .check_s2_i  (check_s2_i),
    .check_d_i   (check_d_i),
    .check_pc_i  (check_pc_i),
    .pc_id_i     (pc_id_i),
    .rs1_tag_i   (rs1_tag_i),
    .rs2_tag_i   (rs2_tag_i),
    .rd_tag_i    (rd_tag_i),
    .pc_tag_i    (pc_tag_i),
    .exc_ack_i   (exc_ack_i),
    .flush_i     (flush_i),
    .clear_i     (clear_i),
    .exc_req_o   (exc_req_o),
    .exc_cause_o (exc_cause_o),
    .exc_pc_o    (exc_pc_o),
    .ex_stall_o  (ex_stall_o),
    .viol_cnt_o  (viol_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic int ref_cause(input bit [3:0] h);
    int bitpos[4] = '{3, 2, 1, 0};
    int code[4]   = '{4, 1, 2, 3};
    for (int i = 0; i < 4; i++)
      if (h[bitpos[i]]) return code[i];
    return 0;
  endfunction

  function automatic int exp_cnt();
`ifdef TAG_CHECK_COUNTER_EN
    return m_cnt;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_valid = 0; m_chk = '0; m_ex_pc = '0;
    m_pending = 0; m_blocked = 0; m_cause = 0; m_pc = '0; m_cnt = 0;
  endtask

  task automatic drive_idle();
    id_valid_i = 0; ex_ready_i = 0; check_s1_i = 0; check_s2_i = 0;
    check_d_i = 0; check_pc_i = 0; pc_id_i = '0; rs1_tag_i = 0;
    rs2_tag_i = 0; rd_tag_i = 0; pc_tag_i = 0; exc_ack_i = 0;
    flush_i = 0; clear_i = 0;
  endtask

  // One cycle: drive, compare against the model, advance the model, clock.
  task automatic step(input bit v, input bit rdy, input bit [3:0] en,
                      input bit [PC_W-1:0] pc, input bit [3:0] tags,
                      input bit ack, input bit fl, input bit clr);
    bit [3:0] h;
    bit       viol, stall;
    id_valid_i = v; ex_ready_i = rdy;
    check_pc_i = en[3]; check_s1_i = en[2]; check_s2_i = en[1]; check_d_i = en[0];
    pc_id_i = pc;
    pc_tag_i = tags[3]; rs1_tag_i = tags[2]; rs2_tag_i = tags[1]; rd_tag_i = tags[0];
    exc_ack_i = ack; flush_i = fl; clear_i = clr;
    #1;
    h     = m_chk & tags;
    viol  = m_valid && !m_pending && !m_blocked && (h != 0);
    stall = viol || m_pending || m_blocked;
    check("req",   exc_req_o,   m_pending);
    check("stall", ex_stall_o,  stall);
    check("cause", exc_cause_o, m_cause);
    check("pc",    exc_pc_o,    m_pc);
    check("cnt",   viol_cnt_o,  exp_cnt());
    if (m_pending) begin
      if (ack) begin
        m_pending = 0;
        m_blocked = !fl;
      end
    end else if (m_blocked) begin
      if (fl) m_blocked = 0;
      if (clr) begin m_cause = 0; m_pc = '0; end
    end else if (viol && !fl) begin
      m_pending = 1;
      m_cause   = ref_cause(h);
      m_pc      = m_ex_pc;
      if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
    end else if (clr) begin
      m_cause = 0; m_pc = '0;
    end
    if (clr) m_cnt = 0;
    if (fl) m_valid = 0;
    else if (rdy && !stall) begin
      m_valid = v; m_chk = en; m_ex_pc = pc;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // load an instruction, raise a violation, ack, then flush back to idle
  task automatic one_violation(input bit [PC_W-1:0] pc, input bit clr_on_viol);
    step(1, 1, 4'b0100, pc, 4'b0000, 0, 0, 0);
    step(0, 1, 4'b0000, '0, 4'b0100, 0, 0, clr_on_viol);
    step(0, 1, 4'b0000, '0, 4'b0000, 1, 0, 0);
    step(0, 1, 4'b0000, '0, 4'b0000, 0, 1, 0);
  endtask

  initial begin
    drive_idle();
    model_reset();
    rst = 1;
    #2;
    check("rst_req",   exc_req_o,   0);
    check("rst_stall", ex_stall_o,  0);
    check("rst_cause", exc_cause_o, 0);
    check("rst_pc",    exc_pc_o,    0);
    check("rst_cnt",   viol_cnt_o,  0);
    @(negedge clk); @(negedge clk);
    rst = 0;

    // basic S1 violation, ack three cycles after the request
    step(1, 1, 4'b0100, 32'h100, 4'b0000, 0, 0, 0);
    step(0, 1, 4'b0000, '0, 4'b0100, 0, 0, 0);
    check("s1_req",   exc_req_o,   1);
    check("s1_cause", exc_cause_o, 1);
    check("s1_pc",    exc_pc_o,    32'h100);
    step(0, 1, 4'b0000, '0, 4'b0100, 0, 0, 0);
    step(0, 1, 4'b0000, '0, 4'b0000, 0, 1, 0);  // flush alone keeps request
    step(0, 1, 4'b0000, '0, 4'b0000, 1, 0, 0);
    check("blk_req",   exc_req_o,  0);
    check("blk_stall", ex_stall_o, 1);
    step(0, 1, 4'b0000, '0, 4'b0000, 1, 0, 0);  // ack in BLOCK ignored
    step(0, 1, 4'b0000, '0, 4'b0000, 0, 1, 0);
    step(0, 1, 4'b0000, '0, 4'b0000, 0, 0, 0);

    // cause priority cases
    step(1, 1, 4'b1111, 32'h200, 4'b0000, 0, 0, 0);
    step(0, 1, 4'b0000, '0, 4'b1111, 0, 0, 0);
    check("prio_pc", exc_cause_o, 4);
    step(0, 1, 4'b0000, '0, 4'b0000, 1, 1, 0);  // ack+flush: straight to idle
    step(1, 1, 4'b0111, 32'h204, 4'b0000, 0, 0, 0);
    step(0, 1, 4'b0000, '0, 4'b1111, 0, 0, 0);
    check("prio_s1", exc_cause_o, 1);
    step(0, 1, 4'b0000, '0, 4'b0000, 1, 0, 0);
    step(0, 1, 4'b0000, '0, 4'b0000, 0, 1, 1);  // clear in BLOCK
    step(1, 1, 4'b0001, 32'h208, 4'b0000, 0, 0, 0);
    step(0, 1, 4'b0000, '0, 4'b0001, 0, 0, 0);
    check("prio_d", exc_cause_o, 3);
    step(0, 1, 4'b0000, '0, 4'b0000, 0, 0, 1);  // clear in REQ ignored
    step(0, 1, 4'b0000, '0, 4'b0000, 1, 1, 0);

    // violation coincident with flush
    step(1, 1, 4'b0010, 32'h300, 4'b0000, 0, 0, 0);
    step(0, 1, 4'b0000, '0, 4'b0010, 0, 1, 0);
    step(0, 1, 4'b0000, '0, 4'b0010, 0, 0, 0);

    // enables without tags, and tagged bubbles
    for (int i = 0; i < 10; i++)
      step(i % 2, 1, 4'b1111, 32'h400 + 4 * i, (i % 2) ? 4'b0000 : 4'b1111, 0, 0, 0);

    // asynchronous reset while requesting
    step(1, 1, 4'b0010, 32'h500, 4'b0000, 0, 0, 0);
    step(0, 1, 4'b0000, '0, 4'b0010, 0, 0, 0);
    #2 rst = 1;
    #1;
    check("arst_req",   exc_req_o,   0);
    check("arst_stall", ex_stall_o,  0);
    check("arst_cause", exc_cause_o, 0);
    check("arst_pc",    exc_pc_o,    0);
    check("arst_cnt",   viol_cnt_o,  0);
    model_reset();
    drive_idle();
    @(negedge clk);
    rst = 0;
    step(1, 1, 4'b1000, 32'h600, 4'b0000, 0, 0, 0);
    step(0, 1, 4'b0000, '0, 4'b1000, 0, 0, 0);
    check("post_rst_req", exc_req_o, 1);
    step(0, 1, 4'b0000, '0, 4'b0000, 1, 1, 0);
    step(0, 1, 4'b0000, '0, 4'b0000, 0, 0, 1);

    // counter saturation and clear on a coinciding increment
    for (int i = 0; i < 5; i++) one_violation(32'h700 + 4 * i, 0);
    one_violation(32'h800, 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit [3:0] tg;
      for (int k = 0; k < 4; k++) tg[k] = ($urandom_range(0, 3) == 0);
      step($urandom_range(0, 1), $urandom_range(0, 4) != 0, 4'($urandom_range(0, 15)),
           $urandom, tg, $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 9) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
